ep_add_arbiter: RTL and testbench

EP_ADD_ARBITER -- requirements
Module: ep_add_arbiter

---
 rtl/ep_arb_pkg.sv | 16 +
 rtl/rr_pick.sv | 34 +++
 rtl/ep_add_arbiter.sv | 110 +++++++++++
 tb/tb_ep_add_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ep_arb_pkg.sv
// Shared types for the round-robin adder arbiter.
// Holds the FSM state encoding and the id-width helper.
package ep_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a requester index; never below one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker.
// req: request vector, ptr: highest-priority index.
// gnt: one-hot grant, idx: grant index, any: some request present.
module rr_pick
  import ep_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = id_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan from ptr upward, wrapping, and take the first hit.
  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/ep_add_arbiter.sv
// Shared adder with round-robin arbitration between N_REQ requesters.
// Ports: okClk/reset (sync, active-high); req_valid/req_ready/req_a/req_b
// per requester; res_valid/res_ready/res_data/res_id result; busy.
module ep_add_arbiter
  import ep_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int DW    = 32,
  localparam int IW    = id_w(N_REQ)
) (
  input  logic                okClk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*DW-1:0] req_a,
  input  logic [N_REQ*DW-1:0] req_b,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [DW:0]         res_data,
  output logic [IW-1:0]       res_id,
  output logic                busy
);

  state_t st, nst;

  logic [IW-1:0]    ptr;
  logic [IW-1:0]    id_q;
  logic [DW-1:0]    a_q;
  logic [DW-1:0]    b_q;
  logic [DW:0]      sum_q;

  logic [N_REQ-1:0] pk_gnt;
  logic [IW-1:0]    pk_idx;
  logic             pk_any;

  logic             take;
  logic             hs;
  logic [DW-1:0]    a_sel;
  logic [DW-1:0]    b_sel;
  logic [IW-1:0]    ptr_nx;

  rr_pick #(
    .N (N_REQ)
  ) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .gnt (pk_gnt),
    .idx (pk_idx),
    .any (pk_any)
  );

  // Grant is suppressed while reset is high so nothing is
  // handed out on a cycle whose capture would be thrown away.
  assign take  = (st == IDLE) && pk_any && !reset;
  assign hs    = (st == DONE) && res_ready;

  assign a_sel = req_a[pk_idx*DW +: DW];
  assign b_sel = req_b[pk_idx*DW +: DW];

  assign ptr_nx = (id_q == IW'(N_REQ - 1))
                ? '0
                : id_q + 1'b1;

  always_ff @(posedge okClk) begin
    if (reset) begin
      st <= IDLE;
    end else begin
      st <= nst;
    end
  end

  always_comb begin
    nst = st;
    unique case (st)
      IDLE:    if (pk_any) nst = EXEC;
      EXEC:    nst = DONE;
      DONE:    if (res_ready) nst = IDLE;
      default: nst = IDLE;
    endcase
  end

  always_ff @(posedge okClk) begin
    if (reset) begin
      ptr   <= '0;
      id_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
    end else begin
      if (take) begin
        a_q  <= a_sel;
        b_q  <= b_sel;
        id_q <= pk_idx;
      end
      if (st == EXEC) begin
        sum_q <= {1'b0, a_q} + {1'b0, b_q};
      end
      if (hs) begin
        ptr <= ptr_nx;
      end
    end
  end

  assign req_ready = take ? pk_gnt : '0;
  assign res_valid = (st == DONE);
  assign res_data  = sum_q;
  assign res_id    = id_q;
  assign busy      = (st != IDLE);

endmodule

// File: tb/tb_ep_add_arbiter.sv
// Directed plus random bench for ep_add_arbiter.
// Checks against a transaction-level model.
module tb_ep_add_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            okClk;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic            res_valid;
  logic            res_ready;
  logic [DW:0]     res_data;
  logic [1:0]      res_id;
  logic            busy;

  ep_add_arbiter #(
    .N_REQ (N),
    .DW    (DW)
  ) dut (
    .okClk     (okClk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .busy      (busy)
  );

  initial okClk = 1'b0;
  always #5 okClk = ~okClk;

  int nchk  = 0;
  int npass = 0;
  int nfail = 0;
  int cyc_n = 0;

  // Model: one outstanding job, cycles since accept, pointer.
  int          m_ptr   = 0;
  bit          m_out   = 0;
  int          m_since = 0;
  logic [DW:0] m_data  = '0;
  int          m_id    = 0;

  logic [N-1:0] obs_ready;
  int gid_q[$];
  int gcyc_q[$];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nchk++;
    assert (got === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v,
                              input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic set_op(input int i,
                        input logic [DW-1:0] a,
                        input logic [DW-1:0] b);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
  endtask

  task automatic cyc(input logic rst,
                     input logic [N-1:0] v,
                     input logic rr);
    logic [N-1:0] er;
    bit ev;
    int g;
    reset     = rst;
    req_valid = v;
    res_ready = rr;
    #1;
    g  = pick(v, m_ptr);
    er = (!m_out && !rst && g >= 0) ? (4'b0001 << g) : 4'b0000;
    ev = m_out && (m_since >= 2);
    obs_ready = req_ready;
    chk("req_ready", req_ready, er);
    chk("busy", busy, m_out);
    chk("res_valid", res_valid, ev);
    if (ev) begin
      chk("res_data", res_data, m_data);
      chk("res_id", res_id, m_id);
    end
    if (er != 0) begin
      gid_q.push_back(g);
      gcyc_q.push_back(cyc_n);
    end
    if (rst) begin
      m_out = 0;
      m_ptr = 0;
    end else if (!m_out) begin
      if (g >= 0) begin
        m_out   = 1;
        m_since = 1;
        m_id    = g;
        m_data  = {1'b0, req_a[g*DW +: DW]}
                + {1'b0, req_b[g*DW +: DW]};
      end
    end else if (m_since >= 2) begin
      if (rr) begin
        m_out = 0;
        m_ptr = (m_id + 1) % N;
      end
    end else begin
      m_since++;
    end
    @(posedge okClk);
    @(negedge okClk);
    cyc_n++;
  endtask

  task automatic drain2();
    cyc(1'b0, 4'b0000, 1'b1);
    cyc(1'b0, 4'b0000, 1'b1);
  endtask

  initial begin
    logic [DW-1:0] ra, rb;
    logic [DW:0]   bp_exp;
    reset     = 1'b1;
    req_valid = 4'b1111;
    res_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    repeat (2) @(posedge okClk);
    @(negedge okClk);
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", res_data, 0);
    chk("rst_id", res_id, 0);
    cyc(1'b1, 4'b1111, 1'b0);

    // single request
    set_op(0, 32'd5, 32'd7);
    cyc(1'b0, 4'b0001, 1'b1);
    chk("single_ready", obs_ready, 4'b0001);
    cyc(1'b0, 4'b0000, 1'b1);
    chk("single_valid", res_valid, 1);
    chk("single_data", res_data, 12);
    chk("single_id", res_id, 0);
    cyc(1'b0, 4'b0000, 1'b1);

    // carry out
    set_op(1, 32'hFFFF_FFFF, 32'h0000_0001);
    cyc(1'b0, 4'b0010, 1'b1);
    chk("carry_ready", obs_ready, 4'b0010);
    cyc(1'b0, 4'b0000, 1'b1);
    chk("carry_data", res_data, 33'h1_0000_0000);
    chk("carry_id", res_id, 1);
    cyc(1'b0, 4'b0000, 1'b1);

    // fairness from reset
    cyc(1'b1, 4'b0000, 1'b0);
    gid_q.delete();
    gcyc_q.delete();
    for (int i = 0; i < N; i++) set_op(i, DW'(i * 10), DW'(i + 1));
    repeat (15) cyc(1'b0, 4'b1111, 1'b1);
    chk("fair_cnt", gid_q.size(), 5);
    for (int k = 0; k < 5; k++) begin
      if (gid_q.size() > k) begin
        chk("fair_id", gid_q[k], k % N);
        chk("fair_gap", gcyc_q[k] - gcyc_q[0], 3 * k);
      end
    end
    drain2();

    // backpressure
    ra = $urandom;
    rb = $urandom;
    bp_exp = {1'b0, ra} + {1'b0, rb};
    set_op(2, ra, rb);
    cyc(1'b0, 4'b0100, 1'b1);
    chk("bp_grant", obs_ready, 4'b0100);
    cyc(1'b0, 4'b0000, 1'b0);
    repeat (10) begin
      cyc(1'b0, 4'b1111, 1'b0);
      chk("bp_ready", obs_ready, 4'b0000);
      chk("bp_valid", res_valid, 1);
      chk("bp_data", res_data, bp_exp);
      chk("bp_id", res_id, 2);
    end
    cyc(1'b0, 4'b0000, 1'b1);
    chk("bp_idle", busy, 0);

    // reset during EXEC
    cyc(1'b0, 4'b0001, 1'b1);
    chk("mid_grant", obs_ready, 4'b0001);
    cyc(1'b1, 4'b1010, 1'b1);
    chk("mid_valid", res_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_data", res_data, 0);
    cyc(1'b0, 4'b1010, 1'b1);
    chk("mid_next", obs_ready, 4'b0010);
    drain2();

    // pointer wrap 3 -> 0
    cyc(1'b0, 4'b0100, 1'b1);
    chk("wrap_g2", obs_ready, 4'b0100);
    drain2();
    cyc(1'b0, 4'b1000, 1'b1);
    chk("wrap_g3", obs_ready, 4'b1000);
    drain2();
    cyc(1'b0, 4'b0011, 1'b1);
    chk("wrap_g0", obs_ready, 4'b0001);
    drain2();
    cyc(1'b0, 4'b0011, 1'b1);
    chk("wrap_g1", obs_ready, 4'b0010);
    drain2();

    // random traffic
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0)
          set_op(i, 32'hFFFF_FFFF, $urandom);
        else
          set_op(i, $urandom, $urandom);
      end
      cyc($urandom_range(0, 49) == 0,
          4'($urandom_range(0, 15)),
          $urandom_range(0, 9) < 7);
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
